fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the decode stage.
// The master modport is the fetch unit's view; slave is the memory/decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic        halted;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc_out, pc_plus1, halted,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc_out, pc_plus1, halted,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at pc, holds it for decode until accepted,
// then advances sequentially or to a redirect target; stops for good on HLT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'b1111
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t      state, nextState;
    logic [15:0] pc, nextPc;
    logic [15:0] instrReg, nextInstr;
    logic        rstDone;
    logic        imemReqQ, instrValidQ, haltedQ;
    logic        handshake;

    assign handshake = instrValidQ && bus.instr_ready;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        nextState = state;
        nextPc    = pc;
        nextInstr = instrReg;
        case (state)
            // rstDone stretches IDLE to one full cycle after the reset release edge.
            IDLE: if (rstDone) nextState = REQ;
            REQ: begin
                if (bus.imem_ack) begin
                    nextInstr = bus.imem_rdata;
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    if (instrReg[15:12] == HLT_OPC) begin
                        nextState = HALT;
                    end else begin
                        nextPc    = bus.redirect ? bus.redirect_pc : pc + 16'd1;
                        nextState = REQ;
                    end
                end
            end
            HALT:    nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instrReg    <= 16'h0000;
            rstDone     <= 1'b0;
            imemReqQ    <= 1'b0;
            instrValidQ <= 1'b0;
            haltedQ     <= 1'b0;
        end else begin
            state       <= nextState;
            pc          <= nextPc;
            instrReg    <= nextInstr;
            rstDone     <= 1'b1;
            imemReqQ    <= (nextState == REQ);
            instrValidQ <= (nextState == HOLD);
            haltedQ     <= (nextState == HALT);
        end
    end

    assign bus.imem_req    = imemReqQ;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instrReg;
    assign bus.opcode      = instrReg[15:12];
    assign bus.instr_valid = instrValidQ;
    assign bus.pc_out      = pc;
    assign bus.pc_plus1    = pc + 16'd1;
    assign bus.halted      = haltedQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table on a RESET_PC=0 instance,
// plus hand-written wrap/halt and asynchronous reset sequences.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if busW ();

    fetch_unit #(.RESET_PC(16'h0000), .HLT_OPC(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_unit #(.RESET_PC(16'hFFFF), .HLT_OPC(4'hF)) dutW (.clk(clk), .rst_n(rst_n), .bus(busW));

    typedef struct {
        logic [15:0] addr;       // expected imem_addr for this fetch
        logic [15:0] data;       // word returned by memory
        int          ackDelay;   // cycles of imem_ack=0 before the ack
        int          stall;      // cycles of instr_ready=0 while held
        logic        redirect;
        logic [15:0] redirectPc;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    localparam int NVEC = 7;
    vec_t vecs[NVEC];
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq();
        for (int n = 0; n < 20 && bus.imem_req !== 1'b1; n++) tick();
        check("req_seen", bus.imem_req, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        {bus.imem_ack, bus.imem_rdata, bus.instr_ready, bus.redirect, bus.redirect_pc} = '0;
        {busW.imem_ack, busW.imem_rdata, busW.instr_ready, busW.redirect, busW.redirect_pc} = '0;

        //          addr      data      ack stall redir target
        vecs[0] = '{16'h0000, 16'h0123, 0, 0, 1'b0, 16'h0000};  // ADD
        vecs[1] = '{16'h0001, 16'h2456, 0, 0, 1'b0, 16'h0000};  // SUB
        vecs[2] = '{16'h0002, 16'h3789, 3, 5, 1'b0, 16'h0000};  // AND, slow mem + backpressure
        vecs[3] = '{16'h0003, 16'hB00A, 1, 0, 1'b1, 16'h0010};
        vecs[4] = '{16'h0010, 16'hC0AB, 0, 2, 1'b1, 16'h0040};  // JAL-like redirect
        vecs[5] = '{16'h0040, 16'h4321, 2, 1, 1'b0, 16'h0000};
        vecs[6] = '{16'h0041, 16'hF000, 0, 0, 1'b1, 16'h1234};  // HLT, redirect ignored

        // Reset state
        tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_instr", bus.instr, 16'h0000);
        check("rst_pc", bus.pc_out, 16'h0000);
        check("rst_pcW", busW.pc_out, 16'hFFFF);
        rst_n = 1'b1;
        tick();
        check("idle_edge1_req", bus.imem_req, 0);
        tick();
        check("edge2_req", bus.imem_req, 1);
        check("edge2_reqW", busW.imem_req, 1);
        check("edge2_addrW", busW.imem_addr, 16'hFFFF);

        // Vector table on the RESET_PC=0 instance
        for (int v = 0; v < NVEC; v++) begin
            waitReq();
            check("imem_addr", bus.imem_addr, vecs[v].addr);
            for (int c = 0; c < vecs[v].ackDelay; c++) begin
                tick();
                check("req_held", bus.imem_req, 1);
                check("addr_stable", bus.imem_addr, vecs[v].addr);
                check("no_valid_wait", bus.instr_valid, 0);
            end
            bus.imem_ack = 1'b1;
            bus.imem_rdata = vecs[v].data;
            sb.push_back('{vecs[v].addr, vecs[v].data});
            tick();
            bus.imem_ack = 1'b0;
            bus.imem_rdata = 16'h0BAD;
            check("valid_after_ack", bus.instr_valid, 1);
            check("req_dropped", bus.imem_req, 0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr", bus.instr, e.instr);
                check("opcode", bus.opcode, e.instr[15:12]);
                check("pc_out", bus.pc_out, e.pc);
                check("pc_plus1", bus.pc_plus1, e.pc + 16'd1);
            end
            for (int c = 0; c < vecs[v].stall; c++) begin
                bus.redirect = 1'b1;
                bus.redirect_pc = 16'hDEAD;
                bus.imem_ack = c[0];
                bus.imem_rdata = 16'hEEEE;
                tick();
                check("stall_instr", bus.instr, e.instr);
                check("stall_pc", bus.pc_out, e.pc);
                check("stall_req", bus.imem_req, 0);
                check("stall_valid", bus.instr_valid, 1);
            end
            bus.imem_ack = 1'b0;
            bus.redirect = vecs[v].redirect;
            bus.redirect_pc = vecs[v].redirectPc;
            bus.instr_ready = 1'b1;
            tick();
            bus.instr_ready = 1'b0;
            bus.redirect = 1'b0;
            check("valid_one_cycle", bus.instr_valid, 0);
        end
        check("sb_empty", sb.size(), 0);

        // After HLT: halted, no further requests, ack ignored
        check("halted", bus.halted, 1);
        for (int c = 0; c < 6; c++) begin
            bus.imem_ack = c[0];
            bus.instr_ready = 1'b1;
            tick();
            check("halt_no_req", bus.imem_req, 0);
            check("halt_no_valid", bus.instr_valid, 0);
            check("halt_stays", bus.halted, 1);
        end
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;

        // Wrap and halt on the RESET_PC=FFFF instance (waiting in REQ since reset)
        check("w_req", busW.imem_req, 1);
        check("w_addr", busW.imem_addr, 16'hFFFF);
        busW.imem_ack = 1'b1;
        busW.imem_rdata = 16'h0ABC;
        tick();
        busW.imem_ack = 1'b0;
        check("w_valid", busW.instr_valid, 1);
        check("w_pc_out", busW.pc_out, 16'hFFFF);
        check("w_pc_plus1", busW.pc_plus1, 16'h0000);
        busW.instr_ready = 1'b1;
        tick();
        busW.instr_ready = 1'b0;
        check("w_wrap_req", busW.imem_req, 1);
        check("w_wrap_addr", busW.imem_addr, 16'h0000);
        busW.imem_ack = 1'b1;
        busW.imem_rdata = 16'hF000;
        tick();
        busW.imem_ack = 1'b0;
        check("w_hlt_opcode", busW.opcode, 4'hF);
        busW.instr_ready = 1'b1;
        busW.redirect = 1'b1;
        busW.redirect_pc = 16'h5555;
        tick();
        busW.instr_ready = 1'b0;
        busW.redirect = 1'b0;
        for (int c = 0; c < 4; c++) begin
            busW.imem_ack = 1'b1;
            tick();
            check("w_halted", busW.halted, 1);
            check("w_no_req", busW.imem_req, 0);
            check("w_no_valid", busW.instr_valid, 0);
        end
        busW.imem_ack = 1'b0;

        // Asynchronous reset mid-HOLD (and mid-REQ on the other instance)
        rst_n = 1'b0;
        #2;
        check("rst2_haltedW", busW.halted, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("r_req", bus.imem_req, 1);
        check("r_addr", bus.imem_addr, 16'h0000);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h1234;
        tick();
        bus.imem_ack = 1'b0;
        check("r_hold_valid", bus.instr_valid, 1);
        check("r_reqW_mid", busW.imem_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", bus.instr_valid, 0);
        check("async_pc", bus.pc_out, 16'h0000);
        check("async_instr", bus.instr, 16'h0000);
        check("async_reqW", busW.imem_req, 0);
        check("async_pcW", busW.pc_out, 16'hFFFF);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hABCD;
        tick();
        check("discard_instr", bus.instr, 16'h0000);
        check("discard_valid", bus.instr_valid, 0);
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        check("re_idle_req", bus.imem_req, 0);
        tick();
        check("re_req", bus.imem_req, 1);
        check("re_addr", bus.imem_addr, 16'h0000);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h5678;
        tick();
        bus.imem_ack = 1'b0;
        check("re_instr", bus.instr, 16'h5678);
        check("re_opcode", bus.opcode, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
